// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared types and constants for the framed UART ALU
package uart_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_A    = 3'd1,
        S_GET_B    = 3'd2,
        S_EXEC     = 3'd3,
        S_SEND_RES = 3'd4,
        S_SEND_FLG = 3'd5,
        S_SEND_ERR = 3'd6
    } state_e;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam logic [7:0] ERR_BYTE    = 8'hEE;

endpackage

// File: rtl/uart_alu_seq_if.sv
// rtl/uart_alu_seq_if.sv - rx strobe, tx byte stream and display outputs of the UART ALU
interface uart_alu_seq_if #(
    parameter int W = 8
);
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         busy;
    logic         err;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, result, flags, busy, err
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, result, flags, busy, err
    );
endinterface

// File: rtl/uart_alu_seq_alu_core.sv
// rtl/uart_alu_seq_alu_core.sv - combinational W-bit ALU with Z/N/C/V flags
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  op_e          op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o,
    output logic         z_o,
    output logic         n_o,
    output logic         c_o,
    output logic         v_o
);

    logic [W:0] wide;

    always_comb begin
        wide = '0;
        y_o  = '0;
        c_o  = 1'b0;
        v_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide = {1'b0, a_i} + {1'b0, b_i};
                y_o  = wide[W-1:0];
                c_o  = wide[W];
                v_o  = (a_i[W-1] == b_i[W-1]) && (y_o[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                // The borrow lands in wide[W]; carry means "no borrow".
                wide = {1'b0, a_i} - {1'b0, b_i};
                y_o  = wide[W-1:0];
                c_o  = ~wide[W];
                v_o  = (a_i[W-1] != b_i[W-1]) && (y_o[W-1] != a_i[W-1]);
            end
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_SHL: begin
                if (32'(b_i) < W) begin
                    wide = {1'b0, a_i} << b_i;
                    y_o  = wide[W-1:0];
                    c_o  = wide[W];
                end
            end
            OP_SHR: begin
                // A guard bit below the LSB catches the last bit shifted out.
                if (32'(b_i) < W) begin
                    wide = {a_i, 1'b0} >> b_i;
                    y_o  = wide[W:1];
                    c_o  = wide[0];
                end
            end
            default: y_o = a_i;
        endcase
    end

    assign z_o = (y_o == '0);
    assign n_o = y_o[W-1];

endmodule

// File: rtl/uart_alu_seq.sv
// rtl/uart_alu_seq.sv - framed UART command parser, ALU sequencer and response streamer
module uart_alu_seq
    import uart_alu_pkg::*;
#(
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic          clk,
    input  logic          rst,
    uart_alu_seq_if.slave bus
);

    localparam int NB  = (W + 7) / 8;
    localparam int BW  = NB * 8;
    localparam int CW  = $clog2(TIMEOUT_CYC + 1);
    localparam int BCW = $clog2(NB + 1);

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [BW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic [CW-1:0]   to_q, to_d;
    logic [W-1:0]    res_q, res_d;
    logic [3:0]      flg_q, flg_d;
    logic [BW-1:0]   sh_q, sh_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            err_q, err_d;

    logic [W-1:0]    y;
    logic [BW-1:0]   y_ext;
    logic            z, n, c, v;
    logic            tx_fire;
    logic            last_byte;

    alu_core #(.W(W)) u_alu (
        .op_i (op_e'(op_q[2:0])),
        .a_i  (a_q[W-1:0]),
        .b_i  (b_q[W-1:0]),
        .y_o  (y),
        .z_o  (z),
        .n_o  (n),
        .c_o  (c),
        .v_o  (v)
    );

    always_comb begin
        y_ext        = '0;
        y_ext[W-1:0] = y;
    end

    assign tx_fire   = tx_valid_q && bus.tx_ready;
    assign last_byte = (bcnt_q == BCW'(NB - 1));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        bcnt_d     = bcnt_q;
        to_d       = to_q;
        res_d      = res_q;
        flg_d      = flg_q;
        sh_d       = sh_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[7:4] == SYNC_NIBBLE) begin
                        op_d    = bus.rx_data[3:0];
                        bcnt_d  = '0;
                        to_d    = '0;
                        state_d = S_GET_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                // A byte arriving on the timeout cycle still counts.
                if (bus.rx_valid) begin
                    to_d = '0;
                    if (state_q == S_GET_A) begin
                        a_d = (a_q >> 8) | (BW'(bus.rx_data) << (BW - 8));
                    end else begin
                        b_d = (b_q >> 8) | (BW'(bus.rx_data) << (BW - 8));
                    end
                    if (last_byte) begin
                        bcnt_d  = '0;
                        state_d = (state_q == S_GET_A) ? S_GET_B : S_EXEC;
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end else if (to_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    a_d     = '0;
                    b_d     = '0;
                    bcnt_d  = '0;
                    to_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + CW'(1);
                end
            end
            S_EXEC: begin
                tx_valid_d = 1'b1;
                bcnt_d     = '0;
                if (!op_q[3]) begin
                    res_d     = y;
                    flg_d     = {v, c, n, z};
                    tx_data_d = y_ext[7:0];
                    sh_d      = y_ext >> 8;
                    state_d   = S_SEND_RES;
                end else begin
                    err_d     = 1'b1;
                    tx_data_d = ERR_BYTE;
                    state_d   = S_SEND_ERR;
                end
            end
            S_SEND_RES: begin
                if (tx_fire) begin
                    if (last_byte) begin
                        tx_data_d = {4'h0, flg_q};
                        state_d   = S_SEND_FLG;
                    end else begin
                        tx_data_d = sh_q[7:0];
                        sh_d      = sh_q >> 8;
                        bcnt_d    = bcnt_q + BCW'(1);
                    end
                end
            end
            S_SEND_FLG, S_SEND_ERR: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            bcnt_q     <= '0;
            to_q       <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            sh_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            bcnt_q     <= bcnt_d;
            to_q       <= to_d;
            res_q      <= res_d;
            flg_q      <= flg_d;
            sh_q       <= sh_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.result   = res_q;
    assign bus.flags    = flg_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_alu_seq.sv
// tb/tb_uart_alu_seq.sv - scoreboard bench for uart_alu_seq at W=8 and W=16
module tb_uart_alu_seq;

    typedef struct {
        logic [7:0]      b;
        bit              last;
        longint unsigned r;
        logic [3:0]      f;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_alu_seq_if #(.W(8))  if8 ();
    uart_alu_seq_if #(.W(16)) if16 ();

    uart_alu_seq #(.W(8),  .TIMEOUT_CYC(100)) dut8  (.clk(clk), .rst(rst), .bus(if8));
    uart_alu_seq #(.W(16), .TIMEOUT_CYC(100)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    exp_t            q8[$];
    exp_t            q16[$];
    int              n_total = 0;
    int              n_pass  = 0;
    int              err_seen[2];
    int              err_exp[2];
    longint unsigned last_r[2];
    logic [3:0]      last_f[2];
    bit              hold[2];
    bit              prev_stall[2];
    logic [7:0]      prev_data[2];

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int qsize(int d);
        return (d != 0) ? q16.size() : q8.size();
    endfunction

    task automatic push(int d, exp_t e);
        if (d != 0) q16.push_back(e);
        else        q8.push_back(e);
    endtask

    // Reference: plain modular arithmetic on the operand values.
    function automatic void model(int w, int op, longint unsigned a_in, longint unsigned b_in,
                                  output longint unsigned y, output logic [3:0] f);
        longint unsigned m, a, b, s;
        bit c, v, sa, sb, sy;
        m = (64'd1 << w) - 1;
        a = a_in & m;
        b = b_in & m;
        c = 0;
        v = 0;
        y = 0;
        case (op)
            0: begin s = a + b; y = s & m; c = s[w]; end
            1: begin y = (a - b) & m; c = (a >= b); end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: begin
                if (b == 0) y = a;
                else if (b < longint'(w)) begin y = (a << b) & m; c = a[w - int'(b)]; end
            end
            6: begin
                if (b == 0) y = a;
                else if (b < longint'(w)) begin y = a >> b; c = a[int'(b) - 1]; end
            end
            default: y = a;
        endcase
        sa = a[w-1];
        sb = b[w-1];
        sy = y[w-1];
        if (op == 0) v = (sa == sb) && (sy != sa);
        if (op == 1) v = (sa != sb) && (sy != sa);
        f = {v, c, sy, (y == 0)};
    endfunction

    task automatic drive_rx(int d, logic vld, logic [7:0] b);
        if (d != 0) begin if16.rx_valid = vld; if16.rx_data = b; end
        else        begin if8.rx_valid  = vld; if8.rx_data  = b; end
    endtask

    task automatic gap(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(int d, logic [7:0] b);
        drive_rx(d, 1'b1, b);
        @(posedge clk); #1;
        drive_rx(d, 1'b0, 8'h00);
    endtask

    function automatic logic busy_of(int d);
        return (d != 0) ? if16.busy : if8.busy;
    endfunction

    task automatic wait_idle(int d);
        int k;
        k = 0;
        gap(2);
        while ((qsize(d) != 0 || busy_of(d)) && k < 3000) begin
            gap(1);
            k++;
        end
        gap(2);
        chk($sformatf("idle_reached_dut%0d", d), (k < 3000), 1);
        chk($sformatf("err_count_dut%0d", d), err_seen[d], err_exp[d]);
    endtask

    task automatic frame(int d, int op, longint unsigned a, longint unsigned b, bit junk);
        int              w, nb;
        longint unsigned y;
        logic [3:0]      f;
        exp_t            e;
        w  = (d != 0) ? 16 : 8;
        nb = w / 8;
        if (op < 8) begin
            model(w, op, a, b, y, f);
            for (int i = 0; i < nb; i++) begin
                e.b = 8'(y >> (8 * i)); e.last = 0; e.r = 0; e.f = 0;
                push(d, e);
            end
            e.b = {4'h0, f}; e.last = 1; e.r = y; e.f = f;
            push(d, e);
            last_r[d] = y;
            last_f[d] = f;
        end else begin
            e.b = 8'hEE; e.last = 1; e.r = last_r[d]; e.f = last_f[d];
            push(d, e);
            err_exp[d]++;
        end
        send(d, {4'hA, 4'(op)});
        for (int i = 0; i < nb; i++) begin gap($urandom_range(0, 3)); send(d, 8'(a >> (8 * i))); end
        for (int i = 0; i < nb; i++) begin gap($urandom_range(0, 3)); send(d, 8'(b >> (8 * i))); end
        if (junk) send(d, 8'h55);
        wait_idle(d);
    endtask

    task automatic mon(int d, logic vld, logic rdy, logic [7:0] data, logic e,
                       longint unsigned res, logic [3:0] flg);
        exp_t x;
        if (rst) begin
            prev_stall[d] = 0;
            return;
        end
        if (e) err_seen[d]++;
        if (prev_stall[d]) begin
            chk($sformatf("tx_hold_valid_dut%0d", d), vld, 1);
            chk($sformatf("tx_hold_data_dut%0d", d), data, prev_data[d]);
        end
        if (vld && rdy) begin
            if (qsize(d) == 0) begin
                n_total++;
                $display("FAIL tx_unexpected_dut%0d: got byte %02h, expected none", d, data);
            end else begin
                x = (d != 0) ? q16.pop_front() : q8.pop_front();
                chk($sformatf("tx_byte_dut%0d", d), data, x.b);
                if (x.last) begin
                    chk($sformatf("result_dut%0d", d), res, x.r);
                    chk($sformatf("flags_dut%0d", d), flg, x.f);
                end
            end
        end
        prev_stall[d] = vld && !rdy;
        prev_data[d]  = data;
    endtask

    always @(negedge clk) begin
        mon(0, if8.tx_valid,  if8.tx_ready,  if8.tx_data,  if8.err,  64'(if8.result),  if8.flags);
        mon(1, if16.tx_valid, if16.tx_ready, if16.tx_data, if16.err, 64'(if16.result), if16.flags);
    end

    always @(posedge clk) begin
        #1;
        if8.tx_ready  = !hold[0] && ($urandom_range(0, 3) != 0);
        if16.tx_ready = !hold[1] && ($urandom_range(0, 3) != 0);
    end

    initial begin
        int              k, d, op, w;
        longint unsigned a, b;
        rst = 1'b1;
        drive_rx(0, 1'b0, 8'h00);
        drive_rx(1, 1'b0, 8'h00);
        if8.tx_ready  = 1'b0;
        if16.tx_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            err_seen[i] = 0; err_exp[i] = 0; last_r[i] = 0; last_f[i] = 0; hold[i] = 0;
            prev_stall[i] = 0; prev_data[i] = 0;
        end
        gap(3);
        chk("rst_outs_dut0", {if8.tx_valid, if8.tx_data, if8.busy, if8.err, if8.flags}, 0);
        chk("rst_result_dut0", if8.result, 0);
        chk("rst_outs_dut1", {if16.tx_valid, if16.tx_data, if16.busy, if16.err, if16.flags}, 0);
        chk("rst_result_dut1", if16.result, 0);
        rst = 1'b0;
        gap(1);

        frame(0, 0, 64'h05, 64'h03, 0);
        chk("tp_add_result", if8.result, 8'h08);
        chk("tp_add_flags", if8.flags, 4'b0000);
        frame(0, 1, 64'h03, 64'h05, 1);
        chk("tp_sub_flags", if8.flags, 4'b0010);
        frame(0, 0, 64'h7F, 64'h01, 0);
        chk("tp_ovf_flags", if8.flags, 4'b1010);
        frame(0, 2, 64'hF0, 64'h0F, 0);
        chk("tp_and_flags", if8.flags, 4'b0001);
        frame(1, 5, 64'h8001, 64'h0004, 0);
        chk("tp_shl4_result", if16.result, 16'h0010);
        frame(1, 5, 64'h8001, 64'h0001, 0);
        chk("tp_shl1_result", if16.result, 16'h0002);
        chk("tp_shl1_flags", if16.flags, 4'b0100);

        send(0, 8'h55);
        err_exp[0]++;
        wait_idle(0);

        frame(0, 9, 64'h01, 64'h02, 0);
        chk("tp_badop_result", if8.result, 8'h00);

        send(0, 8'hA0);
        send(0, 8'h01);
        err_exp[0]++;
        wait_idle(0);
        chk("tp_timeout_busy", if8.busy, 0);

        hold[1] = 1;
        a = 64'($urandom_range(0, 65535));
        b = 64'($urandom_range(0, 65535));
        fork
            frame(1, 0, a, b, 0);
            begin
                k = 0;
                while (!if16.tx_valid && k < 1000) begin gap(1); k++; end
                gap(20);
                hold[1] = 0;
            end
        join

        send(0, 8'hA0);
        send(0, 8'h05);
        rst = 1'b1;
        gap(1);
        chk("midframe_rst_outs", {if8.tx_valid, if8.tx_data, if8.busy, if8.err, if8.flags}, 0);
        chk("midframe_rst_result", if8.result, 0);
        rst = 1'b0;
        last_r[0] = 0; last_f[0] = 0;
        last_r[1] = 0; last_f[1] = 0;
        gap(1);
        frame(0, 0, 64'h05, 64'h03, 0);
        chk("post_rst_result", if8.result, 8'h08);

        for (int i = 0; i < 60; i++) begin
            d  = $urandom_range(0, 1);
            w  = (d != 0) ? 16 : 8;
            op = $urandom_range(0, 9);
            a  = 64'($urandom) & ((64'd1 << w) - 1);
            if (op == 5 || op == 6) b = 64'($urandom_range(0, w + 2));
            else                    b = 64'($urandom) & ((64'd1 << w) - 1);
            frame(d, op, a, b, bit'($urandom_range(0, 1)));
        end

        gap(5);
        chk("final_q8_empty", q8.size(), 0);
        chk("final_q16_empty", q16.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
